// File: rtl/mem_pkg.sv
// Shared definitions for the burst controller and the 256x8 memory it drives.
package mem_pkg;

   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      READ    = 3'd2,
      RD_WAIT = 3'd3,
      DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/mem_burst_ctrl.sv
// Burst read/write sequencer in front of a single-port memory with a
// combinational read port. Commands, write beats and read beats all use
// valid/ready handshakes. Every output, including the memory pins, comes
// straight from a flop.
// Optional feature: define MEM_BURST_CKSUM_EN to add the XOR checksum
// output cksum over all beats of the most recent burst.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WRITE   | wr_ready high, each accepted beat becomes a memory write
// READ    | mem_rd/mem_addr on the memory pins, Dout captured at cycle end
// RD_WAIT | rd_valid high with captured data, waiting for rd_ready
// DONE    | done pulse, then back to IDLE
//
// The memory strobes are scheduled one state ahead: a write beat accepted
// in WRITE shows on mem_wr the following cycle (so the final beat's write
// lands in the DONE cycle), and the transition into READ puts mem_rd up
// while READ is current, so a read beat costs READ + RD_WAIT = 2 cycles.
module mem_burst_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              mem_rst,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
`ifdef MEM_BURST_CKSUM_EN
   ,
   output logic [DATA_W-1:0] cksum
`endif
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [ADDR_W-1:0] r_remaining;
   logic              r_cmd_ready;
   logic              r_wr_ready;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_busy;
   logic              r_done;
   logic              r_mem_rst;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_din;

   logic              w_cmd_acc;
   logic              w_wr_acc;
   logic              w_rd_hs;
   logic              w_last;
   logic [ADDR_W-1:0] w_next_addr;

   // r_cmd_ready is only ever set while in IDLE, r_wr_ready only in WRITE,
   // r_rd_valid only in RD_WAIT, so the handshakes need no state decode.
   assign w_cmd_acc   = r_cmd_ready & cmd_valid;
   assign w_wr_acc    = r_wr_ready & wr_valid;
   assign w_rd_hs     = r_rd_valid & rd_ready;
   assign w_last      = (r_remaining == '0);
   assign w_next_addr = r_cur_addr + 1'b1;

   assign cmd_ready = r_cmd_ready;
   assign wr_ready  = r_wr_ready;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;
   assign busy      = r_busy;
   assign done      = r_done;
   assign mem_rst   = r_mem_rst;
   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   assign mem_addr  = r_mem_addr;
   assign mem_din   = r_mem_din;

   // Burst sequencer with all handshake and memory outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cur_addr  <= '0;
         r_remaining <= '0;
         r_cmd_ready <= 1'b0;
         r_wr_ready  <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_mem_rst   <= 1'b1;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_din   <= '0;
      end else begin
         r_mem_rst <= 1'b0;
         r_done    <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_mem_wr    <= 1'b0;
               r_mem_rd    <= 1'b0;
               if (w_cmd_acc) begin
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_cur_addr  <= cmd_addr;
                  r_remaining <= cmd_len;
                  if (cmd_wr) begin
                     r_wr_ready <= 1'b1;
                     r_state    <= WRITE;
                  end else begin
                     r_mem_addr <= cmd_addr;
                     r_mem_rd   <= 1'b1;
                     r_state    <= READ;
                  end
               end
            end

            WRITE: begin
               r_mem_wr <= w_wr_acc;
               if (w_wr_acc) begin
                  r_mem_addr <= r_cur_addr;
                  r_mem_din  <= wr_data;
                  if (w_last) begin
                     r_wr_ready <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= DONE;
                  end else begin
                     r_cur_addr  <= w_next_addr;
                     r_remaining <= r_remaining - 1'b1;
                  end
               end
            end

            READ: begin
               // mem_addr has been on the pins all cycle, so Dout is settled.
               r_mem_rd   <= 1'b0;
               r_rd_data  <= mem_dout;
               r_rd_valid <= 1'b1;
               r_state    <= RD_WAIT;
            end

            RD_WAIT: begin
               if (w_rd_hs) begin
                  r_rd_valid <= 1'b0;
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_cur_addr  <= w_next_addr;
                     r_remaining <= r_remaining - 1'b1;
                     r_mem_addr  <= w_next_addr;
                     r_mem_rd    <= 1'b1;
                     r_state     <= READ;
                  end
               end
            end

            DONE: begin
               r_mem_wr    <= 1'b0;
               r_mem_rd    <= 1'b0;
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_BURST_CKSUM_EN
   logic [DATA_W-1:0] r_cksum;

   assign cksum = r_cksum;

   // XOR of every beat moved since the last command accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cksum <= '0;
      end else if (w_cmd_acc) begin
         r_cksum <= '0;
      end else if (w_wr_acc) begin
         r_cksum <= r_cksum ^ wr_data;
      end else if (w_rd_hs) begin
         r_cksum <= r_cksum ^ r_rd_data;
      end
   end
`endif

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl with a behavioural 256x8 memory.
module tb_mem_burst_ctrl;
   import mem_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_wr;
   logic [7:0] cmd_addr, cmd_len;
   logic       wr_valid, wr_ready;
   logic [7:0] wr_data;
   logic       rd_valid, rd_ready;
   logic [7:0] rd_data;
   logic       busy, done, mem_rst, mem_rd, mem_wr;
   logic [7:0] mem_addr, mem_din, mem_dout;
`ifdef MEM_BURST_CKSUM_EN
   logic [7:0] cksum;
`endif

   always #5 clk = ~clk;

   mem_burst_ctrl dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .busy(busy), .done(done), .mem_rst(mem_rst),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef MEM_BURST_CKSUM_EN
      , .cksum(cksum)
`endif
   );

   // behavioural memory: synchronous write, combinational read
   logic [7:0] mem [256];
   always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_din;
   assign mem_dout = mem[mem_addr];

   // reference model state
   logic [7:0] ref_mem [256];
   logic [7:0] wdata [256];

   int total = 0;
   int bad   = 0;

   // observation of the memory pins and the done pulse
   logic [7:0] wq_addr [$];
   logic [7:0] wq_data [$];
   longint     wq_time [$];
   int         done_cnt  = 0;
   int         rd_pulse  = 0;
   int         both_cnt  = 0;
   logic       prev_rd   = 1'b0;

   always @(negedge clk) begin
      if (mem_wr) begin
         wq_addr.push_back(mem_addr);
         wq_data.push_back(mem_din);
         wq_time.push_back($time);
      end
      if (done) done_cnt++;
      if (mem_rd && !prev_rd) rd_pulse++;
      if (mem_rd && mem_wr) both_cnt++;
      prev_rd = mem_rd;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int b = 0;
      while (!cmd_ready && b < 600) begin @(negedge clk); b++; end
      check({tag, "_idle"}, cmd_ready, 1);
   endtask

   task automatic issue_cmd(input logic wr, input logic [7:0] a, input logic [7:0] len, input string tag);
      int b = 0;
      while (!cmd_ready && b < 50) begin @(negedge clk); b++; end
      if (!cmd_ready) check({tag, "_cmd_ready"}, cmd_ready, 1);
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = len;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_wr = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] a, input int n, input bit gaps, input string tag);
      int base = wq_addr.size();
      int d0   = done_cnt;
      int acc  = 0;
      int b    = 0;
      int got;
      logic [7:0] ck = 8'h00;
      issue_cmd(1'b1, a, 8'(n - 1), tag);
      while (acc < n && b < 4 * n + 20) begin
         wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         wr_data  = wdata[acc];
         if (wr_valid && wr_ready) begin ck ^= wdata[acc]; acc++; end
         @(negedge clk); b++;
      end
      wr_valid = 1'b0;
      check({tag, "_beats"}, acc, n);
      wait_idle(tag);
      check({tag, "_done"}, done_cnt - d0, 1);
      got = wq_addr.size() - base;
      check({tag, "_nwrites"}, got, n);
      for (int i = 0; i < n && i < got; i++) begin
         check({tag, "_waddr"}, wq_addr[base + i], 8'(a + i));
         check({tag, "_wdata"}, wq_data[base + i], wdata[i]);
      end
      if (!gaps && got == n)
         check({tag, "_wr_consec"}, 32'((wq_time[base + n - 1] - wq_time[base]) / 10), n - 1);
      for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = wdata[i];
`ifdef MEM_BURST_CKSUM_EN
      check({tag, "_cksum"}, cksum, ck);
`endif
   endtask

   task automatic do_read(input logic [7:0] a, input int n, input bit bp, input string tag);
      int p0  = rd_pulse;
      int d0  = done_cnt;
      int got = 0;
      int b   = 0;
      longint prev_t = 0;
      logic [7:0] ck = 8'h00;
      issue_cmd(1'b0, a, 8'(n - 1), tag);
      while (got < n && b < 6 * n + 20) begin
         rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rd_valid && rd_ready) begin
            check({tag, "_rdata"}, rd_data, ref_mem[8'(a + got)]);
            if (!bp && got > 0) check({tag, "_rd_spacing"}, 32'(($time - prev_t) / 10), 2);
            prev_t = $time;
            ck ^= ref_mem[8'(a + got)];
            got++;
         end
         @(negedge clk); b++;
      end
      rd_ready = 1'b0;
      check({tag, "_beats"}, got, n);
      wait_idle(tag);
      check({tag, "_done"}, done_cnt - d0, 1);
      check({tag, "_rd_pulses"}, rd_pulse - p0, n);
`ifdef MEM_BURST_CKSUM_EN
      check({tag, "_cksum"}, cksum, ck);
`endif
   endtask

   initial begin
      int p0, d0, w0, b, n;
      logic [7:0] a;

      rst = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

      // power-on reset state
      @(negedge clk);
      check("por_ctrl", {cmd_ready, wr_ready, rd_valid, busy, done, mem_rd, mem_wr, mem_rst}, 8'b0000_0001);
      check("por_bus", {mem_addr, mem_din, rd_data}, 24'h0);
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      check("por_release", {cmd_ready, busy, mem_rst}, 3'b100);

      // directed 4-beat write and read-back
      for (int i = 0; i < 4; i++) wdata[i] = 8'hA0 + 8'(i);
      do_write(8'h10, 4, 1'b0, "wr4");
      do_read(8'h10, 4, 1'b0, "rd4");

      // wrap-around at the top of the address space
      for (int i = 0; i < 4; i++) wdata[i] = 8'(8'hC5 ^ (i * 37));
      do_write(8'hFE, 4, 1'b0, "wrap_wr");
      do_read(8'hFE, 4, 1'b0, "wrap_rd");

      // single-beat burst
      wdata[0] = 8'h6B;
      do_write(8'h33, 1, 1'b0, "one_wr");
      do_read(8'h33, 1, 1'b0, "one_rd");

      // read backpressure; stray cmd_valid / wr_valid must be ignored
      p0 = rd_pulse; d0 = done_cnt;
      issue_cmd(1'b0, 8'h10, 8'd1, "bp");
      w0 = wq_addr.size();
      b = 0;
      while (!rd_valid && b < 20) begin @(negedge clk); b++; end
      check("bp_valid0", rd_valid, 1);
      check("bp_data0", rd_data, ref_mem[8'h10]);
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h77; cmd_len = 8'h00;
      wr_valid = 1'b1; wr_data = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", rd_valid, 1);
         check("bp_hold_data", rd_data, ref_mem[8'h10]);
      end
      check("bp_no_new_rd", rd_pulse - p0, 1);
      cmd_valid = 1'b0; cmd_wr = 1'b0; wr_valid = 1'b0;
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      b = 0;
      while (!rd_valid && b < 20) begin @(negedge clk); b++; end
      check("bp_valid1", rd_valid, 1);
      check("bp_data1", rd_data, ref_mem[8'h11]);
      check("bp_pulses", rd_pulse - p0, 2);
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      wait_idle("bp");
      check("bp_done", done_cnt - d0, 1);
      check("bp_no_writes", wq_addr.size() - w0, 0);

`ifdef MEM_BURST_CKSUM_EN
      wdata[0] = 8'h5A; wdata[1] = 8'h3C; wdata[2] = 8'hFF;
      do_write(8'h20, 3, 1'b0, "ck_wr");
      check("ck_const", cksum, 8'h99);
`endif

      // randomized bursts with write gaps and read backpressure
      for (int k = 0; k < 6; k++) begin
         a = 8'($urandom);
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
         do_write(a, n, 1'b1, "rnd_wr");
         do_read(a, n, 1'b1, "rnd_rd");
      end

      // full 256-beat burst, read back from a different start so it wraps
      for (int i = 0; i < 256; i++) wdata[i] = 8'($urandom);
      do_write(8'h00, 256, 1'b0, "full_wr");
      do_read(8'hC3, 256, 1'b0, "full_rd");

      // reset in the middle of a write burst
      for (int i = 0; i < 8; i++) wdata[i] = 8'($urandom);
      issue_cmd(1'b1, 8'h80, 8'd7, "rst_mid");
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_data = wdata[i];
         @(negedge clk);
      end
      d0 = done_cnt;
      #2 rst = 1'b0;
      #1;
      check("rst_ctrl", {cmd_ready, wr_ready, rd_valid, busy, done, mem_rd, mem_wr, mem_rst}, 8'b0000_0001);
      check("rst_bus", {mem_addr, mem_din, rd_data}, 24'h0);
      wr_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      check("rst_release", {cmd_ready, busy, mem_rst}, 3'b100);
      check("rst_no_done", done_cnt - d0, 0);

      // a normal burst still works after the abort
      for (int i = 0; i < 3; i++) wdata[i] = 8'($urandom);
      do_write(8'h50, 3, 1'b0, "post_wr");
      do_read(8'h50, 3, 1'b0, "post_rd");

      check("rd_wr_exclusive", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
